// File: rtl/grid_planner.sv
// Closed-loop move planner: issues tracker move words until the reported
// position (cx, cy) matches the latched target, correcting X before Y.
module grid_planner #(
   parameter int unsigned SETTLE   = 4,
   parameter int unsigned MAX_STEP = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] tx,
   input  logic [3:0] ty,
   input  logic [3:0] cx,
   input  logic [3:0] cy,
   output logic [3:0] cmd,
   output logic       cmd_strobe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] moves
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [4:0]  MAXS = 5'(MAX_STEP);

   localparam logic [1:0] DIR_N = 2'b00;
   localparam logic [1:0] DIR_E = 2'b01;
   localparam logic [1:0] DIR_S = 2'b10;
   localparam logic [1:0] DIR_W = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVAL,
      S_ISSUE,
      S_SETTLE,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      gx_q, gx_d;
   logic [3:0]      gy_q, gy_d;
   logic [3:0]      px_q, px_d;
   logic [3:0]      py_q, py_d;
   logic [3:0]      cmd_q, cmd_d;
   logic [3:0]      moves_q, moves_d;
   logic            error_q, error_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [4:0] dist_x, dist_y;
   logic [1:0] mag_x, mag_y;

   // 5-bit distances so the magnitude clamp never sees a wrapped value
   always_comb begin
      dist_x = (gx_q > cx) ? ({1'b0, gx_q} - {1'b0, cx}) : ({1'b0, cx} - {1'b0, gx_q});
      dist_y = (gy_q > cy) ? ({1'b0, gy_q} - {1'b0, cy}) : ({1'b0, cy} - {1'b0, gy_q});
      mag_x  = (dist_x > MAXS) ? MAXS[1:0] : dist_x[1:0];
      mag_y  = (dist_y > MAXS) ? MAXS[1:0] : dist_y[1:0];
   end

   always_comb begin
      state_d = state_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      px_d    = px_q;
      py_d    = py_q;
      cmd_d   = cmd_q;
      moves_d = moves_q;
      error_d = error_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               gx_d    = tx;
               gy_d    = ty;
               error_d = 1'b0;
               moves_d = '0;
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            if (cx != gx_q) begin
               cmd_d   = {mag_x, (gx_q > cx) ? DIR_E : DIR_W};
               state_d = S_ISSUE;
            end else if (cy != gy_q) begin
               cmd_d   = {mag_y, (gy_q > cy) ? DIR_N : DIR_S};
               state_d = S_ISSUE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_ISSUE: begin
            px_d    = cx;
            py_d    = cy;
            if (moves_q != '1) moves_d = moves_q + 4'd1;
            cnt_d   = CW'(SETTLE - 1);
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               if ((cx == px_q) && (cy == py_q)) begin
                  error_d = 1'b1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_EVAL;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gx_q    <= '0;
         gy_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         cmd_q   <= '0;
         moves_q <= '0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         px_q    <= px_d;
         py_q    <= py_d;
         cmd_q   <= cmd_d;
         moves_q <= moves_d;
         error_q <= error_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cmd        = cmd_q;
   assign cmd_strobe = (state_q == S_ISSUE);
   assign busy       = (state_q == S_EVAL) || (state_q == S_ISSUE) || (state_q == S_SETTLE);
   assign done       = (state_q == S_DONE);
   assign error      = error_q;
   assign moves      = moves_q;

endmodule

// File: tb/tb_grid_planner.sv
// Bench for grid_planner: a 2-cycle-latency saturating tracker closes the loop,
// and expected command sequences come from a plain distance-walking planner.
module tb_grid_planner;

   localparam int SETTLE   = 4;
   localparam int MAX_STEP = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] tx, ty;
   logic [3:0] cx, cy;
   logic [3:0] cmd;
   logic       cmd_strobe, busy, done, error;
   logic [3:0] moves;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] pos_x = '0, pos_y = '0;
   logic [3:0] load_x = '0, load_y = '0;
   logic       load_en = 1'b0;
   logic       frozen = 1'b0;
   logic       p1_v = 1'b0;
   logic [3:0] p1_cmd = '0;

   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];

   grid_planner #(.SETTLE(SETTLE), .MAX_STEP(MAX_STEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx(tx), .ty(ty),
      .cx(cx), .cy(cy), .cmd(cmd), .cmd_strobe(cmd_strobe), .busy(busy),
      .done(done), .error(error), .moves(moves)
   );

   always #5 clk = ~clk;

   assign cx = pos_x;
   assign cy = pos_y;

   function automatic int sat(input int v);
      return (v < 0) ? 0 : ((v > 15) ? 15 : v);
   endfunction

   // Tracker model: a strobe sampled at one edge moves the position one edge later
   always @(posedge clk) begin
      if (load_en) begin
         pos_x <= load_x;
         pos_y <= load_y;
         p1_v  <= 1'b0;
      end else begin
         p1_v   <= cmd_strobe && !frozen;
         p1_cmd <= cmd;
         if (p1_v) begin
            case (p1_cmd[1:0])
               2'b00: pos_y <= 4'(sat(int'(pos_y) + int'(p1_cmd[3:2])));
               2'b01: pos_x <= 4'(sat(int'(pos_x) + int'(p1_cmd[3:2])));
               2'b10: pos_y <= 4'(sat(int'(pos_y) - int'(p1_cmd[3:2])));
               default: pos_x <= 4'(sat(int'(pos_x) - int'(p1_cmd[3:2])));
            endcase
         end
      end
   end

   always @(negedge clk) if (cmd_strobe) obs_q.push_back(cmd);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Walk the distance: X until aligned, then Y, each step at most MAX_STEP
   function automatic void plan(input int x, input int y, input int gx, input int gy);
      int d, m;
      exp_q.delete();
      while (x != gx) begin
         d = gx - x;
         m = (d < 0 ? -d : d);
         if (m > MAX_STEP) m = MAX_STEP;
         exp_q.push_back({2'(m), (d > 0) ? 2'b01 : 2'b11});
         x += (d > 0) ? m : -m;
      end
      while (y != gy) begin
         d = gy - y;
         m = (d < 0 ? -d : d);
         if (m > MAX_STEP) m = MAX_STEP;
         exp_q.push_back({2'(m), (d > 0) ? 2'b00 : 2'b10});
         y += (d > 0) ? m : -m;
      end
   endfunction

   task automatic load(input logic [3:0] x, input logic [3:0] y);
      load_x = x; load_y = y; load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_req(input logic [3:0] gx, input logic [3:0] gy,
                          input bit frz, input bit inject);
      int  cyc, exp_cyc, nexp;
      bit  seen;
      plan(int'(pos_x), int'(pos_y), int'(gx), int'(gy));
      nexp = exp_q.size();
      obs_q.delete();
      frozen = frz;
      tx = gx; ty = gy; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check("busy_after_start", busy, 1);
      check("error_cleared", error, 0);
      seen = 0;
      while (!seen && cyc < 400) begin
         if (inject && cyc == 3) begin
            tx = ~gx; ty = ~gy; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done || error) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      check("finished", seen, 1);
      check("busy_at_end", busy, 0);
      if (frz) begin
         check("err_latency", cyc, 2 + SETTLE + 1);
         check("err_flag", error, 1);
         check("err_no_done", done, 0);
         check("err_moves", moves, 1);
         check("err_strobes", obs_q.size(), 1);
         if (obs_q.size() > 0 && nexp > 0) check("err_cmd", obs_q[0], exp_q[0]);
      end else begin
         exp_cyc = 2 + (SETTLE + 2) * nexp;
         check("done_latency", cyc, exp_cyc);
         check("done_flag", done, 1);
         check("no_error", error, 0);
         check("moves", moves, (nexp > 15) ? 15 : nexp);
         check("strobe_count", obs_q.size(), nexp);
         for (int i = 0; i < nexp && i < obs_q.size(); i++)
            check("cmd_seq", obs_q[i], exp_q[i]);
      end
      @(negedge clk);
      check("done_one_cycle", done, 0);
      if (!frz) check("final_pos", {pos_x, pos_y}, {gx, gy});
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n0;
      logic [3:0] rx, ry;
      rst_n = 1'b0; start = 1'b0; tx = '0; ty = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd", cmd, 0);
      check("rst_strobe", cmd_strobe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_moves", moves, 0);
      rst_n = 1'b1;
      @(negedge clk);

      load(4'd0, 4'd0);   run_req(4'd5, 4'd0, 0, 0);
      load(4'd10, 4'd12); run_req(4'd10, 4'd1, 0, 0);
      load(4'd7, 4'd7);   run_req(4'd7, 4'd7, 0, 0);

      load(4'd0, 4'd0);   run_req(4'd2, 4'd0, 1, 0);
      repeat (5) @(negedge clk);
      check("error_sticky", error, 1);
      check("no_extra_strobe", obs_q.size(), 1);
      run_req(4'd2, 4'd0, 0, 0);

      load(4'd3, 4'd3);   run_req(4'd12, 4'd9, 0, 1);

      // Reset while settling after the second move of (0,0)->(15,15)
      load(4'd0, 4'd0);
      obs_q.delete();
      frozen = 1'b0;
      tx = 4'd15; ty = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_strobes", obs_q.size(), 2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_cmd", cmd, 0);
      check("midrst_strobe", cmd_strobe, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_moves", moves, 0);
      rst_n = 1'b1;
      n0 = obs_q.size();
      repeat (20) @(negedge clk);
      check("post_rst_quiet", obs_q.size(), n0);
      check("post_rst_idle", busy, 0);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 1) load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         rx = 4'($urandom_range(0, 15));
         ry = 4'($urandom_range(0, 15));
         run_req(rx, ry, 0, (rx != pos_x || ry != pos_y) && ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
